// File: rtl/jtcop_obj_dma.sv
// jtcop_obj_dma: double-buffered object table for the sprite draw engine.
// A CPU DMA request copies the CPU-side object RAM into the back bank. The
// banks swap at the start of vertical blank, and only after a complete copy.
// The draw engine reads the front bank through tbl_addr/tbl_dout.
//
// Optional feature macro: JTCOP_DMA_BUSREQ_EN
//   When it is defined, the copy requests the CPU bus (bus_req) and only
//   advances while the bus is granted (bus_ack).
//   When it is undefined, the copy runs alongside the CPU and reads a
//   dual-port source RAM.

module jtcop_obj_dma #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          cen,
  input  logic          LVBL,
  input  logic          dma_req,
  output logic          busy,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_dout,
  input  logic [AW-1:0] tbl_addr,
  output logic [DW-1:0] tbl_dout
`ifdef JTCOP_DMA_BUSREQ_EN
  ,
  output logic          bus_req,
  input  logic          bus_ack
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
`ifdef JTCOP_DMA_BUSREQ_EN
  localparam logic [1:0] WAIT = 2'd3;
`endif

  // Both banks share one array. The top address bit selects the bank.
  // The draw engine reads {bank, addr}. The copy writes {~bank, addr}.
  logic [DW-1:0] mem [0:(2**(AW+1))-1];

  logic       bank;      // front bank index
  logic       done;      // back bank holds a complete, unpublished table
  logic       lvbl_l;    // LVBL delayed by one clk, used for edge detection
  logic [1:0] state;
  logic       vb_start;  // LVBL 1->0 edge
  logic       step;      // copy is allowed to advance on this clk
  logic       last;      // the current word is the final word of the table
  logic       we;        // write the current word into the back bank

  assign vb_start = lvbl_l & ~LVBL;
  assign last     = &ram_addr;

`ifdef JTCOP_DMA_BUSREQ_EN
  assign step = cen & bus_ack;
`else
  assign step = cen;
`endif

  // A restart on the same clk drops the in-flight word. It would land in the
  // back bank anyway, but skipping it keeps each copy clean.
  assign we = (state == DATA) && step && !dma_req;

  // Control: VB edge detect, bank swap and the copy state machine.
  // NOTE: state registers use non-blocking assignments, so every read in this
  // block sees pre-edge values. For example, the swap tests the old 'done'
  // and is not affected by a completion on the same clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvbl_l   <= 1'b0;
      bank     <= 1'b0;
      done     <= 1'b0;
      state    <= IDLE;
      busy     <= 1'b0;
      ram_addr <= '0;
`ifdef JTCOP_DMA_BUSREQ_EN
      bus_req  <= 1'b0;
`endif
    end else begin
      lvbl_l <= LVBL;

      // Publish only a finished copy. A copy in progress has done=0, so a
      // partial back bank never reaches the draw engine.
      if (vb_start && done) begin
        bank <= ~bank;
        done <= 1'b0;
      end

      if (dma_req) begin
        // Start or restart from word 0. Any partial copy is abandoned.
        ram_addr <= '0;
        busy     <= 1'b1;
        done     <= 1'b0;
`ifdef JTCOP_DMA_BUSREQ_EN
        bus_req  <= 1'b1;
        state    <= WAIT;
`else
        state    <= ADDR;
`endif
      end else begin
        case (state)
          IDLE: ;
`ifdef JTCOP_DMA_BUSREQ_EN
          WAIT: if (bus_ack) state <= ADDR;
`endif
          // ram_addr has been stable for at least one clk, so the source
          // RAM data is valid by the next pacing enable.
          ADDR: if (step) state <= DATA;
          DATA: begin
            if (step) begin
              if (last) begin
                ram_addr <= '0;
                busy     <= 1'b0;
                done     <= 1'b1;
`ifdef JTCOP_DMA_BUSREQ_EN
                bus_req  <= 1'b0;
`endif
                state    <= IDLE;
              end else begin
                ram_addr <= ram_addr + AW'(1);
                state    <= ADDR;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Copy write port: it only ever targets the back bank.
  // NOTE: the table memory has no reset. Clearing it would need a sweep of
  // every word, and a reset would stop it from mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[{~bank, ram_addr}] <= ram_dout;
  end

  // Draw-engine read port: front bank, registered, runs every clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tbl_dout <= '0;
    else     tbl_dout <= mem[{bank, tbl_addr}];
  end

endmodule

// File: tb/tb_jtcop_obj_dma.sv
// tb_jtcop_obj_dma: self-checking bench for jtcop_obj_dma (AW=10, DW=16).
// The source object RAM is modelled here. Word n of pattern k holds n ^ key.
// Table reads push the expected word onto a queue when the address is driven.
// The word is popped and compared when the registered data comes back.

module tb_jtcop_obj_dma;

  localparam int AW = 10;
  localparam int DW = 16;

  logic          rst, clk, cen, LVBL, dma_req, busy;
  logic [AW-1:0] ram_addr, tbl_addr;
  logic [DW-1:0] ram_dout, tbl_dout;
`ifdef JTCOP_DMA_BUSREQ_EN
  logic          bus_req, bus_ack;
`endif

  jtcop_obj_dma #(.AW(AW), .DW(DW)) dut (
    .rst      (rst),
    .clk      (clk),
    .cen      (cen),
    .LVBL     (LVBL),
    .dma_req  (dma_req),
    .busy     (busy),
    .ram_addr (ram_addr),
    .ram_dout (ram_dout),
    .tbl_addr (tbl_addr),
    .tbl_dout (tbl_dout)
`ifdef JTCOP_DMA_BUSREQ_EN
    ,
    .bus_req  (bus_req),
    .bus_ack  (bus_ack)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source RAM: data follows the address one clk later.
  logic [DW-1:0] src [0:(1<<AW)-1];
  always @(posedge clk) ram_dout <= src[ram_addr];

  // Pacing: cen is high for one full clk in every cen_period clks.
  int cen_period = 1;
  int cen_cnt    = 0;
  always @(negedge clk) begin
    cen_cnt++;
    cen = (cen_cnt % cen_period) == 0;
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q [$];

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a, input logic [DW-1:0] key);
    return {{(DW-AW){1'b0}}, a} ^ key;
  endfunction

  task automatic load(input logic [DW-1:0] key);
    for (int i = 0; i < (1 << AW); i++) src[i] = pat(AW'(i), key);
  endtask

  // Drive a table address, then compare the word registered one clk later.
  task automatic rd(input string name, input logic [AW-1:0] a, input logic [DW-1:0] e);
    @(negedge clk);
    tbl_addr = a;
    exp_q.push_back(e);
    @(negedge clk);
    check(name, tbl_dout, exp_q.pop_front());
  endtask

  // With the bus feature, skip the WAIT->ADDR clk so that cen counting
  // starts on the first clk of the copy proper.
  task automatic skip_wait();
`ifdef JTCOP_DMA_BUSREQ_EN
    @(negedge clk);
`endif
  endtask

  task automatic start_copy();
    @(negedge clk);
    dma_req = 1'b1;
    @(negedge clk);
    dma_req = 1'b0;
    skip_wait();
  endtask

  task automatic vblank();
    @(negedge clk);
    LVBL = 1'b0;
    repeat (3) @(negedge clk);
    LVBL = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_addr(input logic [AW-1:0] a);
    bit hit = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (ram_addr == a) begin
        hit = 1'b1;
        break;
      end
    end
    check("wait_addr_reached", 32'(hit), 32'd1);
  endtask

  // Step clocks until busy drops, counting paced steps taken while busy.
  // Optionally probe the front table at loop index probe_i.
  task automatic run_copy(input int probe_i, input logic [AW-1:0] probe_addr,
                          input logic [DW-1:0] probe_exp, output int ncen);
    bit ended = 1'b0;
    ncen = 0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      if (busy && cen) ncen++;
      #1;
      if (probe_i >= 0 && i == probe_i) begin
        tbl_addr = probe_addr;
        exp_q.push_back(probe_exp);
      end
      if (probe_i >= 0 && i == probe_i + 1) check("mid_copy_read", tbl_dout, exp_q.pop_front());
      if (!busy) begin
        ended = 1'b1;
        break;
      end
    end
    check("copy_ended", 32'(ended), 32'd1);
  endtask

  localparam logic [DW-1:0] K0 = 16'h1111, K1 = 16'hA5A5, K2 = 16'h3C3C,
                            K3 = 16'h0F0F, K4 = 16'h7E81, K5 = 16'hC3C3,
                            K6 = 16'h5AA5, K7 = 16'h9669;

  initial begin
    vec_t vecs [4];
    int   ncen;
    bit   idle_ok;

    vecs[0] = '{addr: 10'd5,    exp: 16'hA5A0};
    vecs[1] = '{addr: 10'd1023, exp: 16'hA65A};
    vecs[2] = '{addr: 10'd0,    exp: 16'hA5A5};
    vecs[3] = '{addr: 10'd512,  exp: 16'hA7A5};

    rst = 1'b1; LVBL = 1'b1; dma_req = 1'b0; tbl_addr = '0;
`ifdef JTCOP_DMA_BUSREQ_EN
    bus_ack = 1'b1;
`endif
    load(K0);
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_tbl_dout", 32'(tbl_dout), 32'd0);
`ifdef JTCOP_DMA_BUSREQ_EN
    check("rst_bus_req", 32'(bus_req), 32'd0);
`endif
    rst = 1'b0;

    // Without a request, nothing moves.
    idle_ok = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (busy !== 1'b0 || ram_addr !== '0) idle_ok = 1'b0;
    end
    check("idle_100clk", 32'(idle_ok), 32'd1);

    // Establish a known front table (K0).
    start_copy();
    run_copy(-1, '0, '0, ncen);
    vblank();
    rd("init_table", 10'd5, pat(10'd5, K0));

    // Full copy at cen every 4th clk. The old table stays visible during the
    // copy and after it, until VB.
    cen_period = 4;
    load(K1);
    start_copy();
    run_copy(1000, 10'd7, pat(10'd7, K0), ncen);
    check("copy_cen_count", 32'(ncen), 32'd2048);
    rd("after_copy_before_vb", 10'd5, pat(10'd5, K0));
    vblank();
    for (int i = 0; i < 4; i++) rd("swap_table", vecs[i].addr, vecs[i].exp);

    // VB in the middle of a copy: no swap. The next VB publishes the table.
    cen_period = 2;
    load(K2);
    start_copy();
    wait_addr(10'd500);
    vblank();
    rd("vb_mid_copy_no_swap", 10'd500, pat(10'd500, K1));
    run_copy(-1, '0, '0, ncen);
    rd("done_before_vb", 10'd9, pat(10'd9, K1));
    vblank();
    rd("second_vb_swap", 10'd500, pat(10'd500, K2));

    // Restart at word 300 with a new source table.
    load(K3);
    start_copy();
    wait_addr(10'd300);
    load(K4);
    @(negedge clk);
    dma_req = 1'b1;
    @(posedge clk);
    #1;
    check("restart_addr", 32'(ram_addr), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    @(negedge clk);
    dma_req = 1'b0;
    skip_wait();
    run_copy(-1, '0, '0, ncen);
    check("restart_cen_count", 32'(ncen), 32'd2048);
    rd("restart_before_vb", 10'd299, pat(10'd299, K2));
    vblank();
    rd("restart_w0", 10'd0, pat(10'd0, K4));
    rd("restart_w299", 10'd299, pat(10'd299, K4));
    rd("restart_w300", 10'd300, pat(10'd300, K4));
    rd("restart_w1023", 10'd1023, pat(10'd1023, K4));

    // VB with no completed copy: front unchanged.
    vblank();
    rd("vb_no_copy", 10'd77, pat(10'd77, K4));

    // Copy completes on the same clk as the LVBL fall: the swap waits.
    cen_period = 1;
    load(K5);
    start_copy();
    wait_addr(10'd1023);
    @(negedge clk);
    LVBL = 1'b0;
    repeat (3) @(negedge clk);
    LVBL = 1'b1;
    check("coincident_busy", 32'(busy), 32'd0);
    rd("coincident_no_swap", 10'd5, pat(10'd5, K4));
    vblank();
    rd("coincident_next_vb", 10'd5, pat(10'd5, K5));

    // dma_req on the swap clk: swap happens, copy fills the new back bank.
    load(K6);
    start_copy();
    run_copy(-1, '0, '0, ncen);
    load(K7);
    @(negedge clk);
    LVBL = 1'b0;
    dma_req = 1'b1;
    @(negedge clk);
    dma_req = 1'b0;
    repeat (2) @(negedge clk);
    LVBL = 1'b1;
    rd("req_on_vb_swapped", 10'd5, pat(10'd5, K6));
    check("req_on_vb_busy", 32'(busy), 32'd1);
    run_copy(-1, '0, '0, ncen);
    rd("req_on_vb_hold", 10'd1023, pat(10'd1023, K6));
    vblank();
    rd("req_on_vb_new", 10'd1023, pat(10'd1023, K7));

`ifdef JTCOP_DMA_BUSREQ_EN
    // Bus handshake: without a grant the copy does not start or advance.
    load(K0);
    bus_ack = 1'b0;
    @(negedge clk);
    dma_req = 1'b1;
    @(negedge clk);
    dma_req = 1'b0;
    check("bus_req_set", 32'(bus_req), 32'd1);
    repeat (20) @(negedge clk);
    check("no_grant_addr", 32'(ram_addr), 32'd0);
    check("no_grant_busy", 32'(busy), 32'd1);
    bus_ack = 1'b1;
    wait_addr(10'd40);
    bus_ack = 1'b0;
    repeat (10) @(negedge clk);
    check("ack_drop_hold", 32'(ram_addr), 32'd40);
    bus_ack = 1'b1;
    run_copy(-1, '0, '0, ncen);
    check("bus_req_clear", 32'(bus_req), 32'd0);
    vblank();
    rd("bus_copy_table", 10'd40, pat(10'd40, K0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
